// File: rtl/mul_unit.sv
// mul_unit: multi-cycle 8x8 shift-add multiplier serving the AVR
// MUL/MULS/MULSU/FMUL/FMULS/FMULSU instructions. It multiplies operand
// magnitudes, then fixes the sign and the fractional shift in one final step.
//
// Handshake: `start` is a request that is accepted only while `busy` is 0
// (state IDLE). While `busy` is 1, `start` is ignored: nothing is queued and
// nothing restarts. The operation completes with a single-cycle `write`
// pulse, with `write_word` high alongside it. `busy` is already 0 in that
// cycle, so a `start` presented there is accepted.
module mul_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [7:0]  a_val,
    input  logic [7:0]  b_val,
    output logic        busy,
    output logic        write,
    output logic        write_word,
    output logic [5:0]  d,
    output logic [15:0] Rd,
    output logic        flag_c,
    output logic        flag_z
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [2:0]  count;
    logic [15:0] acc;
    logic [7:0]  mcand;     // magnitude of a, shifted by count into acc
    logic [7:0]  mplier;    // magnitude of b, scanned bit by bit
    logic        neg;       // product must be negated in FIX
    logic        frac;      // fractional op: result shifted left by one

    // Operand decode, only used on the accepted start cycle
    logic        a_signed;
    logic        b_signed;
    logic        op_frac;
    logic        a_neg;
    logic        b_neg;
    logic [7:0]  a_mag;
    logic [7:0]  b_mag;

    // Final-step values
    logic [15:0] prod;
    logic [15:0] rd_nxt;

    // The destination is always the R1:R0 pair.
    assign d          = 6'd0;
    assign busy       = (state != IDLE);
    assign write_word = write;

    // Decode signedness and fractional mode from op. Unused codes act as MUL.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        op_frac  = 1'b0;
        case (op)
            3'b001: begin a_signed = 1'b1; b_signed = 1'b1; end
            3'b010: begin a_signed = 1'b1; end
            3'b100: begin op_frac = 1'b1; end
            3'b101: begin a_signed = 1'b1; b_signed = 1'b1; op_frac = 1'b1; end
            3'b110: begin a_signed = 1'b1; op_frac = 1'b1; end
            default: ;
        endcase
        a_neg = a_signed & a_val[7];
        b_neg = b_signed & b_val[7];
        // 0x80 negates to 0x80, which is the correct unsigned magnitude.
        a_mag = a_neg ? (~a_val + 8'd1) : a_val;
        b_mag = b_neg ? (~b_val + 8'd1) : b_val;
    end

    // Apply sign and fractional shift to the accumulated magnitude
    always_comb begin
        prod   = neg ? (~acc + 16'd1) : acc;
        rd_nxt = frac ? {prod[14:0], 1'b0} : prod;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next state: eight RUN cycles, one FIX cycle, then back to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (count == 3'd7) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch operands, shift-add, then register the result and flags
    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= 3'd0;
            acc    <= 16'h0000;
            mcand  <= 8'h00;
            mplier <= 8'h00;
            neg    <= 1'b0;
            frac   <= 1'b0;
            Rd     <= 16'h0000;
            flag_c <= 1'b0;
            flag_z <= 1'b0;
            write  <= 1'b0;
        end else begin
            write <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= a_neg ^ b_neg;
                        frac   <= op_frac;
                        acc    <= 16'h0000;
                        count  <= 3'd0;
                    end
                end
                RUN: begin
                    if (mplier[count])
                        acc <= acc + ({8'h00, mcand} << count);
                    count <= count + 3'd1;
                end
                FIX: begin
                    Rd     <= rd_nxt;
                    flag_c <= prod[15];
                    flag_z <= (rd_nxt == 16'h0000);
                    write  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed and random checks of mul_unit against an
// integer-arithmetic reference model.
module tb_mul_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [7:0]  a_val;
    logic [7:0]  b_val;
    logic        busy;
    logic        write;
    logic        write_word;
    logic [5:0]  d;
    logic [15:0] Rd;
    logic        flag_c;
    logic        flag_z;

    int errors = 0;
    int checks = 0;

    // Expected results {flag_c, flag_z, Rd}, pushed at start, popped at write
    logic [17:0] exp_q[$];

    mul_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .a_val      (a_val),
        .b_val      (b_val),
        .busy       (busy),
        .write      (write),
        .write_word (write_word),
        .d          (d),
        .Rd         (Rd),
        .flag_c     (flag_c),
        .flag_z     (flag_z)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: signed/unsigned integer multiply, 16-bit wrap
    function automatic logic [17:0] model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        bit sa, sb, fr;
        int av, bv, pr;
        logic [15:0] p, r;
        sa = 0; sb = 0; fr = 0;
        case (o)
            3'd1: begin sa = 1; sb = 1; end
            3'd2: begin sa = 1; end
            3'd4: begin fr = 1; end
            3'd5: begin sa = 1; sb = 1; fr = 1; end
            3'd6: begin sa = 1; fr = 1; end
            default: ;
        endcase
        av = sa ? {{24{a[7]}}, a} : {24'h0, a};
        bv = sb ? {{24{b[7]}}, b} : {24'h0, b};
        pr = av * bv;
        p  = pr[15:0];
        r  = fr ? {p[14:0], 1'b0} : p;
        return {p[15], (r == 16'h0000), r};
    endfunction

    // Issue one operation and check it through its write cycle.
    // If hammer is set, start stays high with junk operands during RUN/FIX.
    // Returns in the write cycle.
    task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          input bit hammer, input string tag);
        logic [17:0] e;
        exp_q.push_back(model(o, a, b));
        op = o; a_val = a; b_val = b; start = 1'b1;
        tick();                                   // edge N
        start = hammer;
        op    = 3'($urandom_range(0, 7));
        a_val = 8'($urandom);
        b_val = 8'($urandom);
        check({tag, " busy@N"}, 32'(busy), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            tick();                               // edges N+1..N+8
            if (hammer) begin
                op    = 3'($urandom_range(0, 7));
                a_val = 8'($urandom);
                b_val = 8'($urandom);
            end
            check({tag, " busy_run"}, 32'(busy), 32'd1);
            check({tag, " no_early_write"}, 32'(write), 32'd0);
        end
        tick();                                   // edge N+9
        start = 1'b0;
        e = exp_q.pop_front();
        check({tag, " write"}, 32'(write), 32'd1);
        check({tag, " write_word"}, 32'(write_word), 32'd1);
        check({tag, " busy_done"}, 32'(busy), 32'd0);
        check({tag, " d"}, 32'(d), 32'd0);
        check({tag, " Rd"}, 32'(Rd), 32'(e[15:0]));
        check({tag, " flag_c"}, 32'(flag_c), 32'(e[17]));
        check({tag, " flag_z"}, 32'(flag_z), 32'(e[16]));
    endtask

    // Stimulus
    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; a_val = 8'h00; b_val = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        check("rst busy", 32'(busy), 32'd0);
        check("rst write", 32'(write), 32'd0);
        check("rst write_word", 32'(write_word), 32'd0);
        check("rst d", 32'(d), 32'd0);
        check("rst Rd", 32'(Rd), 32'd0);
        check("rst flag_c", 32'(flag_c), 32'd0);
        check("rst flag_z", 32'(flag_z), 32'd0);
        tick();

        // Directed cases
        run_op(3'd0, 8'hFF, 8'hFF, 0, "mul_ff_ff");
        check("mul_ff_ff Rd_const", 32'(Rd), 32'hFE01);
        check("mul_ff_ff c_const", 32'(flag_c), 32'd1);
        tick();
        check("write_one_cycle", 32'(write), 32'd0);
        check("write_word_one_cycle", 32'(write_word), 32'd0);
        check("Rd_held", 32'(Rd), 32'hFE01);

        run_op(3'd1, 8'h80, 8'h80, 0, "muls_80_80");
        check("muls_80_80 Rd_const", 32'(Rd), 32'h4000);
        run_op(3'd2, 8'hFF, 8'h02, 0, "mulsu_ff_02");
        check("mulsu_ff_02 Rd_const", 32'(Rd), 32'hFFFE);
        run_op(3'd0, 8'h00, 8'h37, 0, "mul_00_37");
        check("mul_00_37 z_const", 32'(flag_z), 32'd1);
        run_op(3'd4, 8'h80, 8'h80, 0, "fmul_80_80");
        check("fmul_80_80 Rd_const", 32'(Rd), 32'h8000);
        run_op(3'd5, 8'hC0, 8'h40, 0, "fmuls_c0_40");
        check("fmuls_c0_40 Rd_const", 32'(Rd), 32'hE000);
        check("fmuls_c0_40 c_const", 32'(flag_c), 32'd1);
        run_op(3'd6, 8'h80, 8'hFF, 0, "fmulsu_80_ff");
        run_op(3'd7, 8'hFF, 8'h80, 0, "op7_as_mul");
        tick();

        // Start held during RUN: exactly one write, first operands only
        run_op(3'd0, 8'h12, 8'h34, 1, "hammer");
        tick();
        check("hammer no_second_write", 32'(write), 32'd0);
        check("hammer idle", 32'(busy), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hammer quiet", 32'(write), 32'd0);
        end

        // Back-to-back: second start in the write cycle
        run_op(3'd1, 8'h7F, 8'h81, 0, "b2b_first");
        run_op(3'd0, 8'h0B, 8'h0D, 0, "b2b_second");
        tick();

        // Reset mid-operation at edge N+4
        op = 3'd0; a_val = 8'hAA; b_val = 8'h55; start = 1'b1;
        tick();                                   // edge N
        start = 1'b0;
        for (int i = 1; i <= 3; i++) tick();      // edges N+1..N+3
        reset = 1'b1;
        tick();                                   // edge N+4
        reset = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort Rd", 32'(Rd), 32'd0);
        check("abort flag_c", 32'(flag_c), 32'd0);
        check("abort flag_z", 32'(flag_z), 32'd0);
        for (int i = 0; i < 12; i++) begin
            check("abort no_write", 32'(write), 32'd0);
            tick();
        end
        run_op(3'd0, 8'h03, 8'h05, 0, "after_abort");
        check("after_abort Rd_const", 32'(Rd), 32'h000F);
        tick();

        // Reset has priority over start on the same edge
        reset = 1'b1; start = 1'b1; op = 3'd0; a_val = 8'h09; b_val = 8'h09;
        tick();
        reset = 1'b0; start = 1'b0;
        check("reset_prio busy", 32'(busy), 32'd0);
        tick();
        check("reset_prio still_idle", 32'(busy), 32'd0);

        // Random operations, some back-to-back
        for (int n = 0; n < 40; n++) begin
            run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                   bit'($urandom_range(0, 1)), "random");
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
